alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter that shares one external `alu` instance between the execute stage (port 0) and a secondary requester such as branch/address compare (port 1). It accepts valid/ready requests carrying an `AluControl` opcode and two operands, and drives the shared ALU combinationally for the granted port. It registers the ALU `result`/`zero` into a per-port response slot that is held until consumed. It sits between the pipeline control and the single combinational `alu` datapath.

## Interface
- `XLEN`, 32, operand/result width; must match the `alu` instance.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `p0_req_valid` / `p1_req_valid` input 1: request present.
- `p0_req_ready` / `p1_req_ready` output 1: request accepted this cycle.
- `p0_req_op` / `p1_req_op` input 4: `AluControl` code.
- `p0_req_a`, `p0_req_b`, `p1_req_a`, `p1_req_b` input XLEN: operands.
- `p0_rsp_valid` / `p1_rsp_valid` output 1: response slot full.
- `p0_rsp_ready` / `p1_rsp_ready` input 1: consumer takes response.
- `p0_rsp_result` / `p1_rsp_result` output XLEN: registered ALU result.
- `p0_rsp_zero` / `p1_rsp_zero` output 1: registered ALU zero flag.
- `p0_rsp_err` / `p1_rsp_err` output 1: opcode was illegal.
- `alu_op` output 4: to shared ALU `AluControl`.
- `alu_a`, `alu_b` output XLEN: to shared ALU operands.
- `alu_result` input XLEN, `alu_zero` input 1: from shared ALU.

## Operation
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 NOT (a only), 0110 SLL, 0111 SRL, 1000 SRA. Codes 1001–1111 are illegal.
- Port i is eligible when `pi_req_valid` && !(`pi_rsp_valid` && !`pi_rsp_ready`): a full slot that is being drained in the same cycle allows back-to-back operation.
- At most one grant per cycle. `pi_req_ready` = grant[i]. This ready depends combinationally on valid.
- The granted port's op/a/b drive `alu_op`/`alu_a`/`alu_b`. With no grant, the block drives op=0000 and a=b=0.
- On the grant edge, the granted port's slot loads `alu_result`/`alu_zero`, sets `pi_rsp_err`=0, and sets `pi_rsp_valid`=1.
- An illegal opcode is still granted. Its slot loads result=0, zero=1, err=1.
- The slot clears (`rsp_valid`→0) on the edge where `rsp_valid && rsp_ready`, unless the same port is granted on that edge, in which case the slot reloads. Result, zero and err hold their values while valid and not consumed.
- Arbitration state is a 1-bit `last` register holding the port granted most recently. It resets to 1, so port 0 wins the first tie. It updates only on a grant.

## Timing
- Reset: all outputs 0. That is, `pi_req_ready`, `pi_rsp_valid`, `pi_rsp_result`, `pi_rsp_zero`, `pi_rsp_err` are 0, and `alu_op`/`alu_a`/`alu_b` are 0 (no grant). `last` is 1.
- Asserting `rst_n` mid-operation drops all pending responses immediately. The bench must see `rsp_valid`=0 before the next edge.
- Latency: handshake on edge N, response valid after edge N (visible during cycle N+1).
- Throughput: 1 op/cycle total. A single port sustains 1 op/cycle when its consumer holds `rsp_ready`=1.
- Requesters must hold op/a/b stable while valid and not ready.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. When both ports are eligible, grant the port ≠ `last`. Under continuous contention, grants alternate 0,1,0,1.
- `ALU_ARB_RR_EN` undefined: fixed priority. Port 0 always wins when eligible, and `last` is still maintained but unused. Port 1 can starve.

## Test plan
- Reset: hold `rst_n`=0 with both requests valid → all ready/valid/result outputs 0. Assert reset mid-response → `p0_rsp_valid` falls without waiting for a clock edge.
- Single op: p0 ADD a=5, b=2 → `p0_req_ready`=1 that cycle. Next cycle `p0_rsp_valid`=1, result=7, zero=0, err=0. `alu_op`=0000 when idle.
- Zero and illegal: p1 SUB 6−6 → result 0, zero=1. p1 op 1010 → result 0, zero=1, err=1.
- Contention: both ports valid for 4 cycles with `rsp_ready`=1. With the macro → grant order 0,1,0,1. Without the macro → 0,0,0,0 with `p1_req_ready` never 1.
- Backpressure: p0 completes AND 0101&0011, then `p0_rsp_ready`=0 for 3 cycles with p0 still requesting → `p0_req_ready`=0, slot holds 0001. Meanwhile p1 SLL 0x80000005<<1 is served → result 0x0000000A.
- Drain and refill: `p0_rsp_ready`=1 and a new p0 request on the same edge → slot reloads and `p0_rsp_valid` stays 1 with no bubble.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one combinational ALU, with a registered
// per-port response slot. Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_SRA = 4'b1000
  } alu_op_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_SRA);
  endfunction

endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            p0_req_valid,
  output logic            p0_req_ready,
  input  logic [3:0]      p0_req_op,
  input  logic [XLEN-1:0] p0_req_a,
  input  logic [XLEN-1:0] p0_req_b,
  output logic            p0_rsp_valid,
  input  logic            p0_rsp_ready,
  output logic [XLEN-1:0] p0_rsp_result,
  output logic            p0_rsp_zero,
  output logic            p0_rsp_err,

  input  logic            p1_req_valid,
  output logic            p1_req_ready,
  input  logic [3:0]      p1_req_op,
  input  logic [XLEN-1:0] p1_req_a,
  input  logic [XLEN-1:0] p1_req_b,
  output logic            p1_rsp_valid,
  input  logic            p1_rsp_ready,
  output logic [XLEN-1:0] p1_rsp_result,
  output logic            p1_rsp_zero,
  output logic            p1_rsp_err,

  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            err;
  } slot_t;

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [3:0]      req_op [2];
  logic [XLEN-1:0] req_a  [2];
  logic [XLEN-1:0] req_b  [2];

  logic [1:0]      eligible;
  logic [1:0]      grant;

  slot_t           slot_q [2];
  slot_t           slot_d [2];
  logic            last_q;
  logic            last_d;

  assign req_valid = {p1_req_valid, p0_req_valid};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};
  assign req_op[0] = p0_req_op;
  assign req_op[1] = p1_req_op;
  assign req_a[0]  = p0_req_a;
  assign req_a[1]  = p1_req_a;
  assign req_b[0]  = p0_req_b;
  assign req_b[1]  = p1_req_b;

  // A full slot that drains on this edge can accept a new result on the same edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = req_valid[i] && !(slot_q[i].valid && !rsp_ready[i]);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    // Ready must read 0 while reset is held, even with requests valid.
    if (rst_n) begin
`ifdef ALU_ARB_RR_EN
      if (&eligible) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
`else
      if (eligible[0]) begin
        grant = 2'b01;
      end else if (eligible[1]) begin
        grant = 2'b10;
      end
`endif
    end
  end

  always_comb begin
    alu_op = 4'(OP_AND);
    alu_a  = '0;
    alu_b  = '0;
    if (grant[0]) begin
      alu_op = req_op[0];
      alu_a  = req_a[0];
      alu_b  = req_b[0];
    end else if (grant[1]) begin
      alu_op = req_op[1];
      alu_a  = req_a[1];
      alu_b  = req_b[1];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].valid && rsp_ready[i]) begin
        slot_d[i].valid = 1'b0;
      end
      if (grant[i]) begin
        slot_d[i].valid = 1'b1;
        if (op_legal(req_op[i])) begin
          slot_d[i].result = alu_result;
          slot_d[i].zero   = alu_zero;
          slot_d[i].err    = 1'b0;
        end else begin
          slot_d[i].result = '0;
          slot_d[i].zero   = 1'b1;
          slot_d[i].err    = 1'b1;
        end
      end
    end
  end

  // Tracks the most recent grant; only the round-robin build consults it.
  always_comb begin
    last_d = last_q;
    if (grant[1]) begin
      last_d = 1'b1;
    end else if (grant[0]) begin
      last_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
      end
      last_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= slot_d[i];
      end
      last_q <= last_d;
    end
  end

  assign p0_req_ready  = grant[0];
  assign p1_req_ready  = grant[1];

  assign p0_rsp_valid  = slot_q[0].valid;
  assign p0_rsp_result = slot_q[0].result;
  assign p0_rsp_zero   = slot_q[0].zero;
  assign p0_rsp_err    = slot_q[0].err;

  assign p1_rsp_valid  = slot_q[1].valid;
  assign p1_rsp_result = slot_q[1].result;
  assign p1_rsp_zero   = slot_q[1].zero;
  assign p1_rsp_err    = slot_q[1].err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of arbitration and response slots.
module tb_alu_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            p0_req_valid, p1_req_valid;
  logic            p0_req_ready, p1_req_ready;
  logic [3:0]      p0_req_op, p1_req_op;
  logic [XLEN-1:0] p0_req_a, p0_req_b, p1_req_a, p1_req_b;
  logic            p0_rsp_valid, p1_rsp_valid;
  logic            p0_rsp_ready, p1_rsp_ready;
  logic [XLEN-1:0] p0_rsp_result, p1_rsp_result;
  logic            p0_rsp_zero, p1_rsp_zero;
  logic            p0_rsp_err, p1_rsp_err;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  int n_vec  = 0;
  int n_fail = 0;

  // Model state: one response slot per port plus the last granted port.
  logic            m_valid [2];
  logic [XLEN-1:0] m_res   [2];
  logic            m_zero  [2];
  logic            m_err   [2];
  logic            m_last;

  logic            obs_g0, obs_g1;
  logic            exp_g0, exp_g1;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_op(p0_req_op), .p0_req_a(p0_req_a), .p0_req_b(p0_req_b),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_result(p0_rsp_result), .p0_rsp_zero(p0_rsp_zero), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_op(p1_req_op), .p1_req_a(p1_req_a), .p1_req_b(p1_req_b),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_result(p1_rsp_result), .p1_rsp_zero(p1_rsp_zero), .p1_rsp_err(p1_rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU; illegal codes return junk that the arbiter must not forward.
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a - b;
      4'd5:    return ~a;
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return XLEN'($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = '0;
      m_zero[i]  = 1'b0;
      m_err[i]   = 1'b0;
    end
    m_last = 1'b1;
  endtask

  task automatic check_slots();
    check("p0_rsp_valid",  p0_rsp_valid,  m_valid[0]);
    check("p0_rsp_result", p0_rsp_result, m_res[0]);
    check("p0_rsp_zero",   p0_rsp_zero,   m_zero[0]);
    check("p0_rsp_err",    p0_rsp_err,    m_err[0]);
    check("p1_rsp_valid",  p1_rsp_valid,  m_valid[1]);
    check("p1_rsp_result", p1_rsp_result, m_res[1]);
    check("p1_rsp_zero",   p1_rsp_zero,   m_zero[1]);
    check("p1_rsp_err",    p1_rsp_err,    m_err[1]);
  endtask

  // One clock cycle: drive, check combinational and registered outputs, advance the model.
  task automatic cycle(input logic v0, input logic [3:0] op0, input logic [XLEN-1:0] a0,
                       input logic [XLEN-1:0] b0, input logic r0,
                       input logic v1, input logic [3:0] op1, input logic [XLEN-1:0] a1,
                       input logic [XLEN-1:0] b1, input logic r1);
    logic e0, e1;
    logic [3:0] eop;
    logic [XLEN-1:0] ea, eb;
    p0_req_valid = v0; p0_req_op = op0; p0_req_a = a0; p0_req_b = b0; p0_rsp_ready = r0;
    p1_req_valid = v1; p1_req_op = op1; p1_req_a = a1; p1_req_b = b1; p1_rsp_ready = r1;
    #3;
    e0 = v0 && !(m_valid[0] && !r0);
    e1 = v1 && !(m_valid[1] && !r1);
`ifdef ALU_ARB_RR_EN
    exp_g0 = e0 && (!e1 || m_last == 1'b1);
`else
    exp_g0 = e0;
`endif
    exp_g1 = e1 && !exp_g0;
    eop = 4'd0; ea = '0; eb = '0;
    if (exp_g0) begin eop = op0; ea = a0; eb = b0; end
    if (exp_g1) begin eop = op1; ea = a1; eb = b1; end
    obs_g0 = p0_req_ready;
    obs_g1 = p1_req_ready;
    check("p0_req_ready", p0_req_ready, exp_g0);
    check("p1_req_ready", p1_req_ready, exp_g1);
    check("alu_op", alu_op, eop);
    check("alu_a",  alu_a,  ea);
    check("alu_b",  alu_b,  eb);
    check_slots();
    @(posedge clk);
    if (m_valid[0] && r0) m_valid[0] = 1'b0;
    if (m_valid[1] && r1) m_valid[1] = 1'b0;
    if (exp_g0 || exp_g1) begin
      int p;
      logic [3:0] op;
      logic [XLEN-1:0] res;
      p   = exp_g1 ? 1 : 0;
      op  = exp_g1 ? op1 : op0;
      res = exp_g1 ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0);
      m_valid[p] = 1'b1;
      if (op > 4'd8) begin
        m_res[p] = '0; m_zero[p] = 1'b1; m_err[p] = 1'b1;
      end else begin
        m_res[p] = res; m_zero[p] = (res == '0); m_err[p] = 1'b0;
      end
      m_last = exp_g1;
    end
    #1;
  endtask

  task automatic idle(input logic r0, input logic r1);
    cycle(1'b0, 4'd0, '0, '0, r0, 1'b0, 4'd0, '0, '0, r1);
  endtask

  logic con0 [4];
  logic con1 [4];

  initial begin
    logic h0, h1;
    logic v0, v1, r0, r1;
    logic [3:0] op0, op1;
    logic [XLEN-1:0] a0, b0, a1, b1;

    model_reset();
    rst_n = 1'b0;
    p0_req_valid = 1'b1; p0_req_op = 4'd2; p0_req_a = 32'd9; p0_req_b = 32'd9; p0_rsp_ready = 1'b1;
    p1_req_valid = 1'b1; p1_req_op = 4'd2; p1_req_a = 32'd3; p1_req_b = 32'd3; p1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rst p0_req_ready", p0_req_ready, 1'b0);
    check("rst p1_req_ready", p1_req_ready, 1'b0);
    check("rst alu_op", alu_op, 4'd0);
    check("rst alu_a",  alu_a,  '0);
    check("rst alu_b",  alu_b,  '0);
    check_slots();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    rst_n = 1'b1;

    // Single ADD on port 0.
    cycle(1'b1, 4'd2, 32'd5, 32'd2, 1'b1, 1'b0, 4'd0, '0, '0, 1'b1);
    check("add p0 granted", obs_g0, 1'b1);
    check("add p0_rsp_valid", p0_rsp_valid, 1'b1);
    check("add result", p0_rsp_result, 32'd7);
    check("add zero", p0_rsp_zero, 1'b0);
    check("add err", p0_rsp_err, 1'b0);
    idle(1'b1, 1'b1);

    // Zero result and illegal opcode on port 1.
    cycle(1'b0, 4'd0, '0, '0, 1'b1, 1'b1, 4'd4, 32'd6, 32'd6, 1'b1);
    check("sub result", p1_rsp_result, 32'd0);
    check("sub zero", p1_rsp_zero, 1'b1);
    cycle(1'b0, 4'd0, '0, '0, 1'b1, 1'b1, 4'b1010, 32'h1234, 32'h1, 1'b1);
    check("illegal result", p1_rsp_result, 32'd0);
    check("illegal zero", p1_rsp_zero, 1'b1);
    check("illegal err", p1_rsp_err, 1'b1);
    idle(1'b1, 1'b1);

    // Contention for four cycles with both consumers ready.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 4'd1, 32'(k), 32'h10, 1'b1, 1'b1, 4'd3, 32'(k), 32'h20, 1'b1);
      con0[k] = obs_g0;
      con1[k] = obs_g1;
    end
`ifdef ALU_ARB_RR_EN
    check("rr grant0", {con0[0], con1[0]}, 2'b10);
    check("rr grant1", {con0[1], con1[1]}, 2'b01);
    check("rr grant2", {con0[2], con1[2]}, 2'b10);
    check("rr grant3", {con0[3], con1[3]}, 2'b01);
`else
    for (int k = 0; k < 4; k++) begin
      check("fixed grant", {con0[k], con1[k]}, 2'b10);
    end
`endif
    idle(1'b1, 1'b1);

    // Backpressure on port 0 while port 1 is served.
    cycle(1'b1, 4'd0, 32'h5, 32'h3, 1'b1, 1'b0, 4'd0, '0, '0, 1'b1);
    check("and granted", obs_g0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 4'd0, 32'h5, 32'h3, 1'b0, (k == 0), 4'd6, 32'h8000_0005, 32'd1, 1'b1);
      check("bp p0_req_ready", obs_g0, 1'b0);
      check("bp p0 hold", p0_rsp_result, 32'h1);
      check("bp p0 valid", p0_rsp_valid, 1'b1);
      if (k == 0) check("sll result", p1_rsp_result, 32'h0000_000A);
    end

    // Drain and refill on the same edge.
    cycle(1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 1'b0, 4'd0, '0, '0, 1'b1);
    check("refill granted", obs_g0, 1'b1);
    check("refill valid", p0_rsp_valid, 1'b1);
    check("refill result", p0_rsp_result, 32'd2);

    // Random traffic; a waiting requester holds its request stable.
    h0 = 1'b0; h1 = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!h0) begin
        v0 = ($urandom_range(0, 3) != 0);
        op0 = 4'($urandom_range(0, 11));
        a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      end
      if (!h1) begin
        v1 = ($urandom_range(0, 3) != 0);
        op1 = 4'($urandom_range(0, 11));
        a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      end
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      cycle(v0, op0, a0, b0, r0, v1, op1, a1, b1, r1);
      h0 = v0 && !exp_g0;
      h1 = v1 && !exp_g1;
    end

    // Reset mid-response drops the slot without a clock edge.
    cycle(1'b1, 4'd2, 32'd4, 32'd4, 1'b0, 1'b1, 4'd1, 32'd1, 32'd2, 1'b0);
    idle(1'b0, 1'b0);
    check("pre-reset p0 valid", p0_rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst p0_rsp_valid", p0_rsp_valid, 1'b0);
    check("async rst p1_rsp_valid", p1_rsp_valid, 1'b0);
    check("async rst p0_rsp_result", p0_rsp_result, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 4'd7, 32'hF0, 32'd4, 1'b1, 1'b1, 4'd8, 32'h8000_0000, 32'd4, 1'b1);
    check("post-reset p0 first", obs_g0, 1'b1);
    check("srl result", p0_rsp_result, 32'h0F);
    idle(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
